// File: rtl/mem_if_pkg.sv
// Shared types and constants for the cache block load/store responder.
// The cache block is four bytes, so the low two address bits select nothing.
package mem_if_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WAIT,
        LOAD_DONE,
        STORE_WAIT,
        STORE_DONE
    } mem_resp_state_t;

    localparam int BL_NUM_BYTES    = 4;
    localparam int BL_OFFSET_W     = $clog2(BL_NUM_BYTES);
    localparam int MEM_LATENCY_MAX = 15;
    localparam int LAT_CNT_W       = $clog2(MEM_LATENCY_MAX + 1);

    // Preload value for the latency down-counter; out-of-range latencies are clamped.
    function automatic logic [LAT_CNT_W-1:0] lat_preload(input int lat);
        if (lat < 1)
            return '0;
        else if (lat > MEM_LATENCY_MAX)
            return LAT_CNT_W'(MEM_LATENCY_MAX - 1);
        else
            return LAT_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_block_array.sv
// Single-port block storage: synchronous write, registered read, no reset.
// A read issued in the same cycle as a write to that address returns the old block.
module mem_block_array #(
    parameter int D_WIDTH = 32,
    parameter int MEM_AW  = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [MEM_AW-1:0]  addr,
    input  logic [D_WIDTH-1:0] wdata,
    output logic [D_WIDTH-1:0] rdata
);

    logic [D_WIDTH-1:0] mem [2**MEM_AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_block_responder.sv
// Memory-side responder: one block load/store at a time, fixed access latency,
// four-phase completion handshake. Define MEM_STORE_ACK_EN to hold store completion until store_ack.
import mem_if_pkg::*;

module mem_block_responder #(
    parameter int D_WIDTH  = 32,
    parameter int WIDTH_AD = 16,
    parameter int MEM_AW   = 8,
    parameter int LATENCY  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH_AD-1:0] address_in,
    input  logic [D_WIDTH-1:0]  data_in,
    output logic [D_WIDTH-1:0]  data_out,
    input  logic                mem_load_req,
    input  logic                wren,
    input  logic                store_ack,
    output logic                load_completed,
    output logic                store_completed,
    output logic                load_toggle,
    output logic                busy
);

    localparam logic [LAT_CNT_W-1:0] CNT_INIT = lat_preload(LATENCY);

    mem_resp_state_t      state;
    logic [LAT_CNT_W-1:0] cnt;
    logic [MEM_AW-1:0]    idx_q;
    logic [MEM_AW-1:0]    req_idx;
    logic [MEM_AW-1:0]    arr_addr;
    logic [D_WIDTH-1:0]   data_q;
    logic [D_WIDTH-1:0]   arr_rdata;
    logic                 arr_we;
    logic                 store_release;

    assign req_idx = address_in[MEM_AW+BL_OFFSET_W-1:BL_OFFSET_W];

    // In IDLE the array reads the incoming index, so the block is already
    // registered by the time a LATENCY=1 load completes.
    assign arr_addr = (state == IDLE) ? req_idx : idx_q;

    // Gated by rst so a store caught by reset never reaches the array.
    assign arr_we = (state == STORE_WAIT) && (cnt == '0) && !rst;

`ifdef MEM_STORE_ACK_EN
    assign store_release = !wren && store_ack;
`else
    logic unused_store_ack;
    assign unused_store_ack = store_ack;
    assign store_release    = !wren;
`endif

    // Byte offset and aliased upper address bits carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address_in[BL_OFFSET_W-1:0],
                                address_in[WIDTH_AD-1:MEM_AW+BL_OFFSET_W]};

    mem_block_array #(
        .D_WIDTH (D_WIDTH),
        .MEM_AW  (MEM_AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (data_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            idx_q           <= '0;
            data_q          <= '0;
            data_out        <= '0;
            load_completed  <= 1'b0;
            store_completed <= 1'b0;
            load_toggle     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A store wins over a simultaneous load; the load is taken later if still held.
                    if (wren) begin
                        idx_q  <= req_idx;
                        data_q <= data_in;
                        cnt    <= CNT_INIT;
                        busy   <= 1'b1;
                        state  <= STORE_WAIT;
                    end else if (mem_load_req) begin
                        idx_q <= req_idx;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                        state <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    load_toggle <= ~load_toggle;
                    if (cnt == '0) begin
                        data_out       <= arr_rdata;
                        load_completed <= 1'b1;
                        state          <= LOAD_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                LOAD_DONE: begin
                    if (!mem_load_req) begin
                        load_completed <= 1'b0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                STORE_WAIT: begin
                    if (cnt == '0) begin
                        store_completed <= 1'b1;
                        state           <= STORE_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STORE_DONE: begin
                    if (store_release) begin
                        store_completed <= 1'b0;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_responder.sv
// Scoreboard bench: drivers push expected completions, a negedge monitor pops and checks them.
// A second instance with LATENCY=4 covers the load_toggle / busy window.
module tb_mem_block_responder;

    localparam int LAT  = 2;
    localparam int LAT4 = 4;
`ifdef MEM_STORE_ACK_EN
    localparam int ACK_EXTRA = 1;
`else
    localparam int ACK_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address_in;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mem_load_req, wren, store_ack;
    logic        load_completed, store_completed, load_toggle, busy;

    logic [15:0] address_in4;
    logic [31:0] data_in4, data_out4;
    logic        mem_load_req4, wren4;
    logic        store_ack4;
    logic        load_completed4, store_completed4, load_toggle4, busy4;

    always #5 clk = ~clk;

    mem_block_responder #(.D_WIDTH(32), .WIDTH_AD(16), .MEM_AW(8), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .address_in(address_in), .data_in(data_in), .data_out(data_out),
        .mem_load_req(mem_load_req), .wren(wren), .store_ack(store_ack),
        .load_completed(load_completed), .store_completed(store_completed),
        .load_toggle(load_toggle), .busy(busy));

    mem_block_responder #(.D_WIDTH(32), .WIDTH_AD(16), .MEM_AW(8), .LATENCY(LAT4)) dut4 (
        .clk(clk), .rst(rst), .address_in(address_in4), .data_in(data_in4), .data_out(data_out4),
        .mem_load_req(mem_load_req4), .wren(wren4), .store_ack(store_ack4),
        .load_completed(load_completed4), .store_completed(store_completed4),
        .load_toggle(load_toggle4), .busy(busy4));

    typedef struct {
        bit          is_load;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [256];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic int blk(input logic [15:0] a);
        return int'(a[9:2]);
    endfunction

    // ---------------- monitor ----------------
    task automatic pop_check(input bit is_load);
        exp_t e;
        if (exp_q.size() == 0) begin
            fail_now(is_load ? "unexpected_load_completion" : "unexpected_store_completion");
            return;
        end
        e = exp_q.pop_front();
        check("completion_kind", 64'(is_load), 64'(e.is_load));
        check("completion_cycle", 64'(cyc), 64'(e.due));
        if (is_load)
            check("load_data", 64'(data_out), 64'(e.data));
    endtask

    logic lc_d = 1'b0;
    logic sc_d = 1'b0;
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (load_completed && !lc_d)  pop_check(1'b1);
            if (store_completed && !sc_d) pop_check(1'b0);
        end
        lc_d = load_completed;
        sc_d = store_completed;
    end

`ifndef MEM_STORE_ACK_EN
    // store_ack must have no effect in this build, so keep it noisy.
    always @(negedge clk) store_ack = 1'($urandom);
`endif

    // ---------------- drivers ----------------
    task automatic wait_flag(input bit want_load);
        int n = 0;
        while (((want_load ? load_completed : store_completed) !== 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if ((want_load ? load_completed : store_completed) !== 1'b1)
            fail_now(want_load ? "timeout_load_completed" : "timeout_store_completed");
    endtask

    // Called at the negedge where store_completed was first seen.
    task automatic finish_store();
        wren = 1'b0;
`ifdef MEM_STORE_ACK_EN
        @(negedge clk);
        check("store_held_without_ack", 64'(store_completed), 64'd1);
        store_ack = 1'b1;
        @(negedge clk);
        store_ack = 1'b0;
`else
        @(negedge clk);
`endif
        check("store_release", 64'(store_completed), 64'd0);
        check("busy_after_store", 64'(busy), 64'd0);
    endtask

    task automatic push_exp(input bit is_load, input logic [31:0] d, input int due);
        exp_t e;
        e.is_load = is_load;
        e.data    = d;
        e.due     = due;
        exp_q.push_back(e);
    endtask

    task automatic do_store(input logic [15:0] a, input logic [31:0] d);
        int acc;
        wren = 1'b1; address_in = a; data_in = d;
        acc = cyc + 1;
        push_exp(1'b0, d, acc + LAT);
        model[blk(a)] = d;
        @(negedge clk);
        address_in = 16'($urandom);
        data_in    = $urandom;
        wait_flag(1'b0);
        finish_store();
    endtask

    task automatic do_load(input logic [15:0] a, input bit short_req);
        int acc;
        mem_load_req = 1'b1; address_in = a;
        acc = cyc + 1;
        push_exp(1'b1, model[blk(a)], acc + LAT);
        @(negedge clk);
        check("busy_in_load", 64'(busy), 64'd1);
        address_in = 16'($urandom);
        if (short_req) mem_load_req = 1'b0;
        wait_flag(1'b1);
        mem_load_req = 1'b0;
        @(negedge clk);
        check("load_release", 64'(load_completed), 64'd0);
    endtask

    // Store and load raised together: store first, then the held load.
    task automatic do_both(input logic [15:0] a, input logic [31:0] d);
        int acc;
        wren = 1'b1; mem_load_req = 1'b1; address_in = a; data_in = d;
        acc = cyc + 1;
        push_exp(1'b0, d, acc + LAT);
        model[blk(a)] = d;
        push_exp(1'b1, d, acc + LAT + 2 + ACK_EXTRA + LAT);
        @(negedge clk);
        data_in = $urandom;
        wait_flag(1'b0);
        finish_store();
        wait_flag(1'b1);
        mem_load_req = 1'b0;
        @(negedge clk);
        check("both_load_release", 64'(load_completed), 64'd0);
    endtask

    function automatic logic [15:0] rand_addr(input int idx);
        return 16'(($urandom_range(0, 63) << 10) | (idx << 2) | $urandom_range(0, 3));
    endfunction

    // ---------------- LATENCY=4 instance ----------------
    task automatic lat4_test();
        int toggles = 0, busy_cnt = 0, n = 0;
        logic prev;
        wren4 = 1'b1; address_in4 = 16'h0020; data_in4 = 32'h5A5A0F0F;
        while (store_completed4 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("lat4_store_done", 64'(store_completed4), 64'd1);
        wren4 = 1'b0;
        @(negedge clk);
        check("lat4_store_release", 64'(busy4), 64'd0);
        mem_load_req4 = 1'b1;
        prev = load_toggle4;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (load_toggle4 !== prev) toggles++;
            prev = load_toggle4;
            if (busy4 === 1'b1) busy_cnt++;
            if (load_completed4 === 1'b1) break;
        end
        check("lat4_load_cycles", 64'(n), 64'(LAT4 + 1));
        check("lat4_load_data", 64'(data_out4), 64'h5A5A0F0F);
        mem_load_req4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (load_toggle4 !== prev) toggles++;
            prev = load_toggle4;
            if (busy4 === 1'b1) busy_cnt++;
        end
        check("lat4_toggle_count", 64'(toggles), 64'(LAT4));
        check("lat4_busy_cycles", 64'(busy_cnt), 64'(LAT4 + 1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
`ifdef MEM_STORE_ACK_EN
        store_ack = 1'b0;
`endif
        rst = 1'b1;
        address_in = '0; data_in = '0; mem_load_req = 1'b0; wren = 1'b0;
        address_in4 = '0; data_in4 = '0; mem_load_req4 = 1'b0; wren4 = 1'b0; store_ack4 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_load_completed", 64'(load_completed), 64'd0);
        check("rst_store_completed", 64'(store_completed), 64'd0);
        check("rst_load_toggle", 64'(load_toggle), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_busy4", 64'(busy4), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        do_store(16'h0004, 32'hCAFE0100);
        do_load(16'h0004, 1'b0);
        do_both(16'h0008, 32'h0000DEAD);
        do_store(16'h0004, 32'h11111111);
        do_store(16'h0404, 32'h22222222);
        do_load(16'h0004, 1'b0);

        // reset while a store is in flight
        do_store(16'h0010, 32'h12345678);
        wren = 1'b1; address_in = 16'h0010; data_in = 32'hBEEF0000;
        @(negedge clk);
        check("busy_store_wait", 64'(busy), 64'd1);
        rst = 1'b1; wren = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_store_completed", 64'(store_completed), 64'd0);
        check("midrst_load_completed", 64'(load_completed), 64'd0);
        check("midrst_data_out", 64'(data_out), 64'd0);
        check("midrst_load_toggle", 64'(load_toggle), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        do_load(16'h0010, 1'b0);

        lat4_test();

        // randomized traffic over a few aliased blocks
        for (int i = 0; i < 8; i++) do_store(rand_addr(i), $urandom);
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: do_store(rand_addr($urandom_range(0, 7)), $urandom);
                1: do_load(rand_addr($urandom_range(0, 7)), 1'b0);
                2: do_load(rand_addr($urandom_range(0, 7)), 1'b1);
                default: do_both(rand_addr($urandom_range(0, 7)), $urandom);
            endcase
        end

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) fail_now("scoreboard_not_drained");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
